// File: rtl/hms_counter_v2.sv
// hms_counter_v2: seconds/minutes/hours counter with up/down modes, checked load,
// UI adjust, 12h display conversion, day counter and event pulses.
`default_nettype none

module hms_counter_v2 #(
  parameter int HOURS_MAX = 23,
  parameter int HOUR_W    = 5,
  parameter int DAY_W     = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              run,
  input  logic              count_down,
  input  logic              mode_12h,
  input  logic              load_en,
  input  logic [5:0]        load_sec,
  input  logic [5:0]        load_min,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic              ui_inc_sec,
  input  logic              ui_inc_min,
  input  logic              ui_inc_hour,
  input  logic              ui_dec,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [HOUR_W-1:0] hours_out,
  output logic              pm,
  output logic [DAY_W-1:0]  days,
  output logic              day_tick,
  output logic              zero_pulse,
  output logic              load_err
);

  localparam logic [HOUR_W-1:0] HMAX = HOUR_W'(HOURS_MAX);
  localparam logic [HOUR_W-1:0] H12  = HOUR_W'(12);
  localparam logic [HOUR_W-1:0] H1   = HOUR_W'(1);

  logic [5:0]        sec_q, sec_d;
  logic [5:0]        min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [DAY_W-1:0]  days_q, days_d;
  logic              day_tick_q, day_tick_d;
  logic              zero_pulse_q, zero_pulse_d;
  logic              load_err_q, load_err_d;

  logic sec_bad, min_bad, hour_bad, at_zero;

  assign sec_bad  = (load_sec > 6'd59);
  assign min_bad  = (load_min > 6'd59);
  assign hour_bad = (load_hour > HMAX);
  assign at_zero  = (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == '0);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sec_q        <= '0;
      min_q        <= '0;
      hour_q       <= '0;
      days_q       <= '0;
      day_tick_q   <= 1'b0;
      zero_pulse_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      days_q       <= days_d;
      day_tick_q   <= day_tick_d;
      zero_pulse_q <= zero_pulse_d;
      load_err_q   <= load_err_d;
    end
  end

  // One action per cycle: load, else UI adjust, else tick; a losing tick is dropped.
  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    days_d       = days_q;
    day_tick_d   = 1'b0;
    zero_pulse_d = 1'b0;
    load_err_d   = 1'b0;
    if (load_en) begin
      sec_d      = sec_bad  ? 6'd0 : load_sec;
      min_d      = min_bad  ? 6'd0 : load_min;
      hour_d     = hour_bad ? '0   : load_hour;
      load_err_d = sec_bad | min_bad | hour_bad;
    end else if (ui_inc_sec) begin
      if (ui_dec) sec_d = (sec_q == 6'd0)  ? 6'd59 : sec_q - 6'd1;
      else        sec_d = (sec_q == 6'd59) ? 6'd0  : sec_q + 6'd1;
    end else if (ui_inc_min) begin
      if (ui_dec) min_d = (min_q == 6'd0)  ? 6'd59 : min_q - 6'd1;
      else        min_d = (min_q == 6'd59) ? 6'd0  : min_q + 6'd1;
    end else if (ui_inc_hour) begin
      if (ui_dec) hour_d = (hour_q == '0)  ? HMAX : hour_q - H1;
      else        hour_d = (hour_q == HMAX) ? '0  : hour_q + H1;
    end else if (run && tick_en) begin
      if (!count_down) begin
        if (sec_q != 6'd59) begin
          sec_d = sec_q + 6'd1;
        end else begin
          sec_d = 6'd0;
          if (min_q != 6'd59) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d = 6'd0;
            if (hour_q != HMAX) begin
              hour_d = hour_q + H1;
            end else begin
              hour_d     = '0;
              days_d     = days_q + DAY_W'(1);
              day_tick_d = 1'b1;
            end
          end
        end
      end else if (!at_zero) begin
        if (sec_q != 6'd0) begin
          sec_d        = sec_q - 6'd1;
          zero_pulse_d = (sec_q == 6'd1) && (min_q == 6'd0) && (hour_q == '0);
        end else begin
          sec_d = 6'd59;
          if (min_q != 6'd0) begin
            min_d = min_q - 6'd1;
          end else begin
            min_d  = 6'd59;
            hour_d = hour_q - H1;
          end
        end
      end
    end
  end

  generate
    if (HOURS_MAX == 23) begin : g_12h
      always_comb begin
        pm = (hour_q >= H12);
        hours_out = hour_q;
        if (mode_12h) begin
          if (hour_q == '0)     hours_out = H12;
          else if (hour_q > H12) hours_out = hour_q - H12;
        end
      end
    end else begin : g_24h
      assign hours_out = hour_q;
      assign pm        = 1'b0;
    end
  endgenerate

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hour_q;
  assign days       = days_q;
  assign day_tick   = day_tick_q;
  assign zero_pulse = zero_pulse_q;
  assign load_err   = load_err_q;

endmodule

`default_nettype wire

// File: doc/hms_counter_v2.md
Name: hms_counter_v2

Overview:
- Parametrised successor to the seconds/minutes/hours counter in the clock datapath.
- Adds:
  - count-down (timer) mode
  - parallel load with range checking
  - bidirectional UI adjust
  - configurable hour range
  - 12h display conversion
  - day counter with rollover pulse
  - zero-reached pulse
- Sits between the 1 Hz enable generator and the display/alarm logic.

Parameters:
- HOURS_MAX, 23, highest hour value; hours count 0..HOURS_MAX.
- HOUR_W, 5, hour field width; must satisfy 2^HOUR_W > HOURS_MAX.
- DAY_W, 8, day counter width; wraps modulo 2^DAY_W.

Ports:
- sys_clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick_en  in  1  1 Hz enable, one sys_clk cycle wide.
- run  in  1  1 = tick_en advances time; 0 = time frozen.
- count_down  in  1  0 = count up (clock); 1 = count down (timer).
- mode_12h  in  1  selects hours_out format.
- load_en  in  1  parallel load strobe.
- load_sec  in  6  seconds value to load.
- load_min  in  6  minutes value to load.
- load_hour  in  HOUR_W  hours value to load.
- ui_inc_sec  in  1  UI adjust seconds.
- ui_inc_min  in  1  UI adjust minutes.
- ui_inc_hour  in  1  UI adjust hours.
- ui_dec  in  1  UI adjust direction: 0 = +1, 1 = -1.
- seconds  out  6  0..59.
- minutes  out  6  0..59.
- hours  out  HOUR_W  0..HOURS_MAX, always 24h-style internal value.
- hours_out  out  HOUR_W  hours, or 1..12 when mode_12h=1 and HOURS_MAX=23.
- pm  out  1  1 when hours >= 12 (HOURS_MAX=23 only, else 0).
- days  out  DAY_W  day count.
- day_tick  out  1  one-cycle pulse on hour rollover to 00:00:00 (up mode).
- zero_pulse  out  1  one-cycle pulse when countdown reaches 00:00:00.
- load_err  out  1  one-cycle pulse when a load field was out of range.

Behaviour:
- Reset (async, immediate): all registered outputs cleared to 0 (seconds, minutes, hours, days, day_tick, zero_pulse, load_err).
  - Reset mid-countdown or mid-load discards the operation.
  - Pulses drop immediately.
- Per-cycle priority:
  - load_en highest, then UI adjust, then tick (run && tick_en).
  - Exactly one action per cycle; a tick coinciding with a load or UI adjust is dropped, not deferred.
- Load:
  - Each field is written independently.
  - A field is out of range if load_sec>59, load_min>59 or load_hour>HOURS_MAX; such a field is written as 0.
  - load_err=1 the cycle after any out-of-range field, else 0.
  - days unchanged by load.
- UI adjust:
  - Field priority is sec > min > hour when multiple inc inputs are high.
  - Only the selected field changes; no carry/borrow into other fields; days unchanged.
  - +1 wraps 59→0 and HOURS_MAX→0; -1 wraps 0→59 and 0→HOURS_MAX.
  - Level-sensitive: adjusts once per cycle while held.
- Up-tick (count_down=0):
  - seconds+1; at 59, wrap to 0 and carry to minutes.
  - minutes at 59: wrap to 0 and carry to hours.
  - hours at HOURS_MAX: wrap to 0, days+1 (wrapping modulo 2^DAY_W), and day_tick=1 for exactly the next cycle.
- Down-tick (count_down=1):
  - If state is already 00:00:00: no change, no pulse (saturate).
  - Otherwise decrement seconds; at 0, borrow (seconds→59, minutes-1).
  - minutes at 0: borrow (minutes→59, hours-1).
  - days never change in down mode.
  - Transition into 00:00:00 asserts zero_pulse for exactly one cycle.
  - Loading 00:00:00 does not pulse.
- Pulses (day_tick, zero_pulse, load_err):
  - Registered, high for one cycle following the causing edge.
  - Otherwise 0.
- hours_out and pm: combinational from the hours register and mode_12h.
  - When HOURS_MAX=23 and mode_12h=1: hours 0→12 (pm=0); 1..11→same (pm=0); 12→12 (pm=1); 13..23→hours-12 (pm=1).
  - When mode_12h=0: hours_out=hours, and pm still reflects hours>=12.
  - When HOURS_MAX≠23: hours_out=hours and pm=0 regardless of mode_12h.
- Changing count_down or mode_12h takes effect on the next tick or output evaluation; no state is altered by the change itself.
- run=0 blocks ticks only; load and UI adjust still operate.

Test Plan:
- Reset then run=1, count_down=0, 60 ticks → 00:01:00, no pulses. Assert rst mid-run → all outputs 0 immediately.
- Load 23:59:58, days=0, two ticks → 23:59:59, then 00:00:00 with days=1 and day_tick high for one cycle. mode_12h=1 at 13:05:00 → hours_out=1, pm=1.
- count_down=1, load 00:01:01, 61 ticks → 00:00:00 with one zero_pulse. A further 3 ticks → state held, no pulse.
- Load sec=60, min=30, hour=24 (HOURS_MAX=23) → 00:30:00, load_err pulse. load_en together with tick_en and ui_inc_sec → only the load applies.
- ui_dec=1, ui_inc_min at 10:00:00 → 10:59:00 (no borrow into hours). ui_inc_sec and ui_inc_hour held together for 2 cycles → seconds +2, hours unchanged.
- Parameter set HOURS_MAX=99, HOUR_W=7: up-count from 99:59:59 → 00:00:00 with day_tick. mode_12h=1 → hours_out=hours, pm=0.
